// File: rtl/axis_burst_scheduler.sv
// axis_burst_scheduler
// Emits trigger-started bursts of ramp data on an AXI4-Stream master port.
// A run is cfg_bursts bursts of cfg_length beats (0..len-1, tlast on the
// final beat), separated by cfg_gap idle cycles. Config is latched at start
// and held until the scheduler returns to IDLE. In continuous mode the run
// wraps back to burst 0 and only stop_flag ends it.

module axis_burst_scheduler #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32,
    parameter     CONTINUOUS       = "FALSE"
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic [CNTR_WIDTH-1:0]       cfg_bursts,
    input  logic [CNTR_WIDTH-1:0]       cfg_gap,
    input  logic                        trg_flag,
    input  logic                        stop_flag,
    output logic                        sts_busy,
    output logic [CNTR_WIDTH-1:0]       sts_burst,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast
);

    localparam bit                  CONT = (CONTINUOUS == "TRUE");
    localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP
    } state_t;

    state_t                state_q,     state_d;
    logic [CNTR_WIDTH-1:0] len_q,       len_d;
    logic [CNTR_WIDTH-1:0] bursts_q,    bursts_d;
    logic [CNTR_WIDTH-1:0] gap_q,       gap_d;
    logic [CNTR_WIDTH-1:0] samp_q,      samp_d;
    logic [CNTR_WIDTH-1:0] burst_q,     burst_d;
    logic [CNTR_WIDTH-1:0] gap_cnt_q,   gap_cnt_d;
    logic                  stop_pend_q, stop_pend_d;

    logic handshake;
    logic last_beat;
    logic last_burst;
    logic stop_now;

    // Outputs decode straight from registers, so reset clears them at once
    // and a stalled beat keeps tdata/tlast stable.
    assign m_axis_tvalid = (state_q == S_RUN);
    assign m_axis_tdata  = AXIS_TDATA_WIDTH'(samp_q);
    assign last_beat     = (samp_q == len_q - ONE);
    assign last_burst    = (burst_q == bursts_q - ONE);
    assign m_axis_tlast  = m_axis_tvalid && last_beat;
    assign handshake     = m_axis_tvalid && m_axis_tready;
    assign stop_now      = stop_pend_q || stop_flag;
    assign sts_busy      = (state_q != S_IDLE);
    assign sts_burst     = burst_q;

    // Next-state logic for the IDLE/RUN/GAP sequencer and its counters.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d     = state_q;
        len_d       = len_q;
        bursts_d    = bursts_q;
        gap_d       = gap_q;
        samp_d      = samp_q;
        burst_d     = burst_q;
        gap_cnt_d   = gap_cnt_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (trg_flag && (cfg_length != '0) && (cfg_bursts != '0) && !stop_flag) begin
                    len_d    = cfg_length;
                    bursts_d = cfg_bursts;
                    gap_d    = cfg_gap;
                    samp_d   = '0;
                    burst_d  = '0;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                // A stop never drops tvalid mid-beat; it is held until the
                // current beat is accepted.
                stop_pend_d = stop_now;
                if (handshake) begin
                    if (stop_now) begin
                        samp_d      = '0;
                        burst_d     = '0;
                        stop_pend_d = 1'b0;
                        state_d     = S_IDLE;
                    end else if (last_beat) begin
                        samp_d = '0;
                        if (last_burst && !CONT) begin
                            burst_d = '0;
                            state_d = S_IDLE;
                        end else begin
                            burst_d = last_burst ? '0 : burst_q + ONE;
                            if (gap_q != '0) begin
                                gap_cnt_d = '0;
                                state_d   = S_GAP;
                            end
                        end
                    end else begin
                        samp_d = samp_q + ONE;
                    end
                end
            end

            S_GAP: begin
                if (stop_flag) begin
                    burst_d = '0;
                    state_d = S_IDLE;
                end else if (gap_cnt_q == gap_q - ONE) begin
                    state_d = S_RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q + ONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            bursts_q    <= '0;
            gap_q       <= '0;
            samp_q      <= '0;
            burst_q     <= '0;
            gap_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            len_q       <= len_d;
            bursts_q    <= bursts_d;
            gap_q       <= gap_d;
            samp_q      <= samp_d;
            burst_q     <= burst_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_pend_q <= stop_pend_d;
        end
    end

endmodule

// File: tb/tb_axis_burst_scheduler.sv
// Directed bench for axis_burst_scheduler: one single-run instance and one
// continuous-mode instance sharing clock, reset, config and tready.

module tb_axis_burst_scheduler;

    logic        clk;
    logic        aresetn;
    logic [31:0] cfg_length;
    logic [31:0] cfg_bursts;
    logic [31:0] cfg_gap;
    logic        tready;

    logic        trg_a, stop_a, busy_a, valid_a, last_a;
    logic [31:0] burst_a, data_a;
    logic        trg_c, stop_c, busy_c, valid_c, last_c;
    logic [31:0] burst_c, data_c;

    int n_cmp = 0;
    int n_err = 0;

    axis_burst_scheduler #(
        .AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32), .CONTINUOUS("FALSE")
    ) u_dut (
        .aclk(clk), .aresetn(aresetn),
        .cfg_length(cfg_length), .cfg_bursts(cfg_bursts), .cfg_gap(cfg_gap),
        .trg_flag(trg_a), .stop_flag(stop_a),
        .sts_busy(busy_a), .sts_burst(burst_a),
        .m_axis_tdata(data_a), .m_axis_tvalid(valid_a),
        .m_axis_tready(tready), .m_axis_tlast(last_a)
    );

    axis_burst_scheduler #(
        .AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32), .CONTINUOUS("TRUE")
    ) u_cont (
        .aclk(clk), .aresetn(aresetn),
        .cfg_length(cfg_length), .cfg_bursts(cfg_bursts), .cfg_gap(cfg_gap),
        .trg_flag(trg_c), .stop_flag(stop_c),
        .sts_busy(busy_c), .sts_burst(burst_c),
        .m_axis_tdata(data_c), .m_axis_tvalid(valid_c),
        .m_axis_tready(tready), .m_axis_tlast(last_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected traces, hand-derived from the burst/gap rules.
    int t1_valid [11] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    int t1_data  [11] = '{0, 1, 2, 3, 0, 0, 0, 0, 1, 2, 3};
    int t1_last  [11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    int t1_burst [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int t2_data  [6]  = '{0, 1, 2, 0, 1, 2};
    int t2_last  [6]  = '{0, 0, 1, 0, 0, 1};
    int t2_burst [6]  = '{0, 0, 0, 1, 1, 1};
    int t4_valid [9]  = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
    int t4_data  [9]  = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
    int t4_last  [9]  = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
    int t4_burst [9]  = '{0, 0, 1, 1, 1, 0, 0, 0, 1};

    logic [19:0] rdy_pat = 20'b1011_0010_1101_0011_0110;

    initial begin
        int          beats;
        int          exp_samp;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;

        aresetn    = 1'b0;
        cfg_length = '0;
        cfg_bursts = '0;
        cfg_gap    = '0;
        tready     = 1'b1;
        trg_a      = 1'b0;
        stop_a     = 1'b0;
        trg_c      = 1'b0;
        stop_c     = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst busy",  busy_a,  0);
        check("rst burst", burst_a, 0);
        check("rst valid", valid_a, 0);
        check("rst last",  last_a,  0);
        check("rst data",  data_a,  0);
        aresetn = 1'b1;
        tick();

        // 1: len=4, bursts=2, gap=3
        cfg_length = 4; cfg_bursts = 2; cfg_gap = 3;
        trg_a = 1'b1;
        tick();
        trg_a = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t1 busy[%0d]", i),  busy_a,  1);
            check($sformatf("t1 valid[%0d]", i), valid_a, t1_valid[i]);
            check($sformatf("t1 burst[%0d]", i), burst_a, t1_burst[i]);
            if (t1_valid[i] != 0) begin
                check($sformatf("t1 data[%0d]", i), data_a, t1_data[i]);
                check($sformatf("t1 last[%0d]", i), last_a, t1_last[i]);
            end
            tick();
        end
        check("t1 end busy",  busy_a,  0);
        check("t1 end valid", valid_a, 0);
        check("t1 end burst", burst_a, 0);

        // 2: len=3, bursts=2, gap=0 -> back-to-back bursts
        cfg_length = 3; cfg_bursts = 2; cfg_gap = 0;
        trg_a = 1'b1;
        tick();
        trg_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2 valid[%0d]", i), valid_a, 1);
            check($sformatf("t2 data[%0d]", i),  data_a,  t2_data[i]);
            check($sformatf("t2 last[%0d]", i),  last_a,  t2_last[i]);
            check($sformatf("t2 burst[%0d]", i), burst_a, t2_burst[i]);
            tick();
        end
        check("t2 end busy", busy_a, 0);

        // 3: len=5, bursts=1, irregular tready
        cfg_length = 5; cfg_bursts = 1; cfg_gap = 0;
        trg_a = 1'b1;
        tick();
        trg_a = 1'b0;
        beats      = 0;
        exp_samp   = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tready = rdy_pat[k % 20];
            check($sformatf("t3 valid[%0d]", k), valid_a, (beats < 5) ? 1 : 0);
            if (valid_a) begin
                check($sformatf("t3 data[%0d]", k), data_a, exp_samp);
                check($sformatf("t3 last[%0d]", k), last_a, (exp_samp == 4) ? 1 : 0);
                if (prev_stall) begin
                    check($sformatf("t3 hold data[%0d]", k), data_a, prev_data);
                    check($sformatf("t3 hold last[%0d]", k), last_a, prev_last);
                end
                prev_stall = !tready;
                prev_data  = data_a;
                prev_last  = last_a;
                if (tready) begin
                    beats++;
                    exp_samp++;
                end
            end else begin
                prev_stall = 1'b0;
            end
            tick();
        end
        tready = 1'b1;
        check("t3 beats", beats, 5);
        check("t3 end busy", busy_a, 0);

        // 5: refused starts and config changes mid-run
        cfg_length = 0; cfg_bursts = 2; cfg_gap = 0;
        trg_a = 1'b1;
        tick();
        check("t5 len0 busy",  busy_a,  0);
        check("t5 len0 valid", valid_a, 0);
        cfg_length = 3; cfg_bursts = 0;
        tick();
        check("t5 bursts0 busy",  busy_a,  0);
        check("t5 bursts0 valid", valid_a, 0);
        cfg_bursts = 1;
        stop_a = 1'b1;
        tick();
        check("t5 stop+trg busy", busy_a, 0);
        stop_a = 1'b0;
        tick();
        trg_a = 1'b0;
        check("t5 run data0", data_a, 0);
        cfg_length = 7; cfg_bursts = 5; cfg_gap = 4;
        tick();
        check("t5 run data1", data_a, 1);
        tick();
        check("t5 run data2", data_a, 2);
        check("t5 run last2", last_a, 1);
        tick();
        check("t5 run end busy",  busy_a,  0);
        check("t5 run end valid", valid_a, 0);

        // 4: continuous mode len=2, bursts=2, gap=1
        cfg_length = 2; cfg_bursts = 2; cfg_gap = 1;
        trg_c = 1'b1;
        tick();
        trg_c = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t4 valid[%0d]", i), valid_c, t4_valid[i]);
            check($sformatf("t4 burst[%0d]", i), burst_c, t4_burst[i]);
            check($sformatf("t4 busy[%0d]", i),  busy_c,  1);
            if (t4_valid[i] != 0) begin
                check($sformatf("t4 data[%0d]", i), data_c, t4_data[i]);
                check($sformatf("t4 last[%0d]", i), last_c, t4_last[i]);
            end
            if (i < 8) tick();
        end
        // Currently in GAP: stop takes effect on the next edge.
        stop_c = 1'b1;
        tick();
        stop_c = 1'b0;
        check("t4 gap stop busy",  busy_c,  0);
        check("t4 gap stop valid", valid_c, 0);
        // Stop in RUN while stalled: the beat is held until accepted.
        trg_c = 1'b1;
        tick();
        trg_c = 1'b0;
        check("t4 restart data", data_c, 0);
        tready = 1'b0;
        stop_c = 1'b1;
        tick();
        stop_c = 1'b0;
        check("t4 stall valid0", valid_c, 1);
        check("t4 stall data0",  data_c,  0);
        tick();
        check("t4 stall valid1", valid_c, 1);
        check("t4 stall data1",  data_c,  0);
        check("t4 stall last1",  last_c,  0);
        tready = 1'b1;
        tick();
        check("t4 run stop busy",  busy_c,  0);
        check("t4 run stop valid", valid_c, 0);

        // 6: asynchronous reset mid-burst, then a fresh start
        cfg_length = 4; cfg_bursts = 1; cfg_gap = 0;
        trg_a = 1'b1;
        tick();
        trg_a = 1'b0;
        tick();
        check("t6 pre data", data_a, 1);
        #2 aresetn = 1'b0;
        #1;
        check("t6 async valid", valid_a, 0);
        check("t6 async data",  data_a,  0);
        check("t6 async busy",  busy_a,  0);
        check("t6 async last",  last_a,  0);
        @(negedge clk);
        aresetn = 1'b1;
        trg_a = 1'b1;
        tick();
        trg_a = 1'b0;
        check("t6 fresh valid", valid_a, 1);
        check("t6 fresh data",  data_a,  0);
        check("t6 fresh burst", burst_a, 0);
        tick();
        check("t6 fresh data1", data_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
